// File: rtl/blueball_motion.sv
// Blue-ball tile motion and sprite pixel offset stage.
// Optional: BLUEBALL_KEY_REPEAT_EN chains moves while a key is held.
module blueball_motion #(
  parameter int START_TX = 1,
  parameter int START_TY = 1,
  parameter int STEP     = 4
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  input  logic        vsync,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        blank,
  input  logic [7:0]  keycode,
  input  logic        wall_n,
  input  logic        wall_e,
  input  logic        wall_s,
  input  logic        wall_w,
  output logic [19:0] DistX,
  output logic [19:0] DistY,
  output logic        sprite_blank,
  output logic [4:0]  tile_x,
  output logic [4:0]  tile_y,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE, S_MOVE, S_HOLD
  } state_t;

  typedef enum logic [1:0] {
    D_UP, D_DN, D_LT, D_RT
  } dir_t;

  localparam logic signed [5:0] STEP_S  = 6'(STEP);
  localparam logic signed [5:0] OFF_END = 6'sd20;

  state_t state, state_nxt;
  dir_t   dir, key_dir;

  logic vsync_d, tick;
  logic key_vld, blocked, go, arrive;
  logic signed [5:0] off_x, off_y;
  logic signed [5:0] off_x_nxt, off_y_nxt;
  logic [10:0] pix_x, pix_y, dx, dy;
  logic hit;

  // Delayed vsync for falling-edge frame tick detection
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) vsync_d <= 1'b1;
    else          vsync_d <= vsync;
  end

  assign tick = vsync_d & ~vsync;

  // Key decode and blocking against walls and grid edges
  always_comb begin
    key_vld = 1'b1;
    key_dir = D_UP;
    unique case (1'b1)
      (keycode == 8'h1A): key_dir = D_UP;
      (keycode == 8'h16): key_dir = D_DN;
      (keycode == 8'h04): key_dir = D_LT;
      (keycode == 8'h07): key_dir = D_RT;
      default:            key_vld = 1'b0;
    endcase
    unique case (key_dir)
      D_UP: blocked = wall_n | (tile_y == 5'd0);
      D_DN: blocked = wall_s | (tile_y == 5'd23);
      D_LT: blocked = wall_w | (tile_x == 5'd0);
      D_RT: blocked = wall_e | (tile_x == 5'd31);
      default: blocked = 1'b1;
    endcase
  end

  assign go = (state == S_IDLE) & tick
            & key_vld & ~blocked;

  // Offset after one step in the latched direction
  always_comb begin
    off_x_nxt = off_x;
    off_y_nxt = off_y;
    unique case (dir)
      D_UP: off_y_nxt = off_y - STEP_S;
      D_DN: off_y_nxt = off_y + STEP_S;
      D_LT: off_x_nxt = off_x - STEP_S;
      D_RT: off_x_nxt = off_x + STEP_S;
      default: ;
    endcase
  end

  assign arrive = (off_x_nxt == OFF_END)
               || (off_x_nxt == -OFF_END)
               || (off_y_nxt == OFF_END)
               || (off_y_nxt == -OFF_END);

  // FSM state register
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (go) state_nxt = S_MOVE;
      S_MOVE:
        if (tick && arrive) begin
`ifdef BLUEBALL_KEY_REPEAT_EN
          state_nxt = S_IDLE;
`else
          state_nxt = S_HOLD;
`endif
        end
      S_HOLD: if (!key_vld) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state == S_MOVE);
  end

  // Tile position, direction and in-flight offset
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      tile_x <= 5'(START_TX);
      tile_y <= 5'(START_TY);
      dir    <= D_RT;
      off_x  <= '0;
      off_y  <= '0;
    end else if (go) begin
      dir   <= key_dir;
      off_x <= '0;
      off_y <= '0;
    end else if (busy && tick) begin
      if (arrive) begin
        off_x <= '0;
        off_y <= '0;
        unique case (dir)
          D_UP: tile_y <= tile_y - 5'd1;
          D_DN: tile_y <= tile_y + 5'd1;
          D_LT: tile_x <= tile_x - 5'd1;
          D_RT: tile_x <= tile_x + 5'd1;
          default: ;
        endcase
      end else begin
        off_x <= off_x_nxt;
        off_y <= off_y_nxt;
      end
    end
  end

  assign pix_x = {6'b0, tile_x} * 11'd20
               + {{5{off_x[5]}}, off_x};
  assign pix_y = {6'b0, tile_y} * 11'd20
               + {{5{off_y[5]}}, off_y};
  assign dx = {1'b0, DrawX} - pix_x;
  assign dy = {1'b0, DrawY} - pix_y;
  assign hit = !dx[10] && (dx < 11'd20)
            && !dy[10] && (dy < 11'd20);

  // Registered sprite-relative offsets and gated blank
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      DistX        <= '0;
      DistY        <= '0;
      sprite_blank <= 1'b0;
    end else begin
      DistX        <= hit ? {9'b0, dx} : '0;
      DistY        <= hit ? {9'b0, dy} : '0;
      sprite_blank <= blank & hit;
    end
  end

endmodule

// File: tb/tb_blueball_motion.sv
// Bench for blueball_motion against a tick-level
// behavioural model of tile moves.
module tb_blueball_motion;

  localparam int STEP = 4;
`ifdef BLUEBALL_KEY_REPEAT_EN
  localparam bit REPEAT = 1'b1;
`else
  localparam bit REPEAT = 1'b0;
`endif

  logic vga_clk = 1'b0;
  logic reset_n = 1'b0;
  logic vsync = 1'b1;
  logic blank = 1'b0;
  logic [9:0] DrawX = '0;
  logic [9:0] DrawY = '0;
  logic [7:0] keycode = '0;
  logic wall_n = 0, wall_e = 0;
  logic wall_s = 0, wall_w = 0;
  logic [19:0] DistX, DistY;
  logic sprite_blank, busy;
  logic [4:0] tile_x, tile_y;

  int n_pass = 0;
  int n_total = 0;

  int m_tx, m_ty, m_cnt, m_dx, m_dy;
  bit m_moving, m_hold;

  blueball_motion #(
    .START_TX(1), .START_TY(1), .STEP(STEP)
  ) dut (
    .vga_clk(vga_clk), .reset_n(reset_n),
    .vsync(vsync), .DrawX(DrawX), .DrawY(DrawY),
    .blank(blank), .keycode(keycode),
    .wall_n(wall_n), .wall_e(wall_e),
    .wall_s(wall_s), .wall_w(wall_w),
    .DistX(DistX), .DistY(DistY),
    .sprite_blank(sprite_blank),
    .tile_x(tile_x), .tile_y(tile_y),
    .busy(busy)
  );

  always #5 vga_clk = ~vga_clk;

  function automatic bit key_ok(
    input logic [7:0] k,
    output int kx, output int ky);
    kx = 0; ky = 0;
    case (k)
      8'h1A: ky = -1;
      8'h16: ky = 1;
      8'h04: kx = -1;
      8'h07: kx = 1;
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_tx = 1; m_ty = 1; m_cnt = 0;
    m_dx = 0; m_dy = 0;
    m_moving = 0; m_hold = 0;
  endtask

  task automatic model_tick();
    int kx, ky, nx, ny;
    bit v, wall;
    v = key_ok(keycode, kx, ky);
    if (m_moving) begin
      m_cnt++;
      if (m_cnt * STEP == 20) begin
        m_tx += m_dx;
        m_ty += m_dy;
        m_moving = 0;
        m_cnt = 0;
        m_hold = !REPEAT && v;
      end
    end else if (!m_hold && v) begin
      nx = m_tx + kx;
      ny = m_ty + ky;
      wall = (kx == 1 && wall_e)
          || (kx == -1 && wall_w)
          || (ky == 1 && wall_s)
          || (ky == -1 && wall_n);
      if (!wall && nx >= 0 && nx <= 31
          && ny >= 0 && ny <= 23) begin
        m_moving = 1;
        m_cnt = 0;
        m_dx = kx;
        m_dy = ky;
      end
    end
  endtask

  function automatic void exp_pix(
    input int x, input int y, input bit b,
    output int ex, output int ey,
    output bit es);
    int px, py, dx, dy;
    px = m_tx * 20;
    py = m_ty * 20;
    if (m_moving) begin
      px += m_dx * STEP * m_cnt;
      py += m_dy * STEP * m_cnt;
    end
    dx = x - px;
    dy = y - py;
    if (dx >= 0 && dx < 20
        && dy >= 0 && dy < 20) begin
      ex = dx; ey = dy; es = b;
    end else begin
      ex = 0; ey = 0; es = 0;
    end
  endfunction

  task automatic do_tick();
    @(negedge vga_clk) vsync = 1'b0;
    @(negedge vga_clk) vsync = 1'b1;
    model_tick();
  endtask

  task automatic set_key(input logic [7:0] k);
    int kx, ky;
    @(negedge vga_clk) keycode = k;
    @(negedge vga_clk);
    if (!key_ok(k, kx, ky)) m_hold = 0;
  endtask

  task automatic drive_pix(
    input int x, input int y, input bit b);
    @(negedge vga_clk);
    DrawX = 10'(x);
    DrawY = 10'(y);
    blank = b;
    @(negedge vga_clk);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge vga_clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    DrawX = 10'd25; DrawY = 10'd22;
    blank = 1'b1;
    repeat (3) @(negedge vga_clk);
    n_total += 6;
    if (tile_x !== 5'd1)
      $display("FAIL rst_tx got %0d want 1",
               tile_x);
    else n_pass++;
    if (tile_y !== 5'd1)
      $display("FAIL rst_ty got %0d want 1",
               tile_y);
    else n_pass++;
    if (busy !== 1'b0)
      $display("FAIL rst_busy got %b want 0",
               busy);
    else n_pass++;
    if (DistX !== 20'd0)
      $display("FAIL rst_dx got %0d want 0",
               DistX);
    else n_pass++;
    if (DistY !== 20'd0)
      $display("FAIL rst_dy got %0d want 0",
               DistY);
    else n_pass++;
    if (sprite_blank !== 1'b0)
      $display("FAIL rst_sb got %b want 0",
               sprite_blank);
    else n_pass++;
    reset_n = 1'b1;
  endtask

  task automatic test_pixel();
    int x, y, ex, ey;
    bit b, es;
    drive_pix(25, 22, 1);
    n_total += 3;
    if (DistX !== 20'd5)
      $display("FAIL pix_dx got %0d want 5",
               DistX);
    else n_pass++;
    if (DistY !== 20'd2)
      $display("FAIL pix_dy got %0d want 2",
               DistY);
    else n_pass++;
    if (sprite_blank !== 1'b1)
      $display("FAIL pix_sb got %b want 1",
               sprite_blank);
    else n_pass++;
    drive_pix(40, 22, 1);
    n_total += 2;
    if (sprite_blank !== 1'b0)
      $display("FAIL pix40_sb got %b want 0",
               sprite_blank);
    else n_pass++;
    if (DistX !== 20'd0)
      $display("FAIL pix40_dx got %0d want 0",
               DistX);
    else n_pass++;
    drive_pix(39, 39, 0);
    n_total += 2;
    if (DistX !== 20'd19)
      $display("FAIL pixnb_dx got %0d want 19",
               DistX);
    else n_pass++;
    if (sprite_blank !== 1'b0)
      $display("FAIL pixnb_sb got %b want 0",
               sprite_blank);
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      x = 20 + $urandom_range(0, 29) - 5;
      y = 20 + $urandom_range(0, 29) - 5;
      b = 1'($urandom_range(0, 1));
      drive_pix(x, y, b);
      exp_pix(x, y, b, ex, ey, es);
      n_total++;
      if (DistX !== 20'(ex) || DistY !== 20'(ey)
          || sprite_blank !== es)
        $display("FAIL pix_rnd (%0d,%0d) got %0d %0d %b want %0d %0d %b",
                 x, y, DistX, DistY,
                 sprite_blank, ex, ey, es);
      else n_pass++;
    end
  endtask

  task automatic test_move_right();
    set_key(8'h07);
    do_tick();
    n_total++;
    if (busy !== 1'b1)
      $display("FAIL mv_start busy got %b want 1",
               busy);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      do_tick();
      drive_pix(24 + 4 * i + 3, 25, 1);
      n_total += 2;
      if (DistX !== 20'(3) || sprite_blank !== 1)
        $display("FAIL mv_pix%0d got %0d %b want 3 1",
                 i, DistX, sprite_blank);
      else n_pass++;
      if (busy !== 1'b1)
        $display("FAIL mv_busy%0d got %b want 1",
                 i, busy);
      else n_pass++;
    end
    do_tick();
    n_total += 2;
    if (tile_x !== 5'd2)
      $display("FAIL mv_end tx got %0d want 2",
               tile_x);
    else n_pass++;
    if (busy !== 1'b0)
      $display("FAIL mv_end busy got %b want 0",
               busy);
    else n_pass++;
    set_key(8'h00);
  endtask

  task automatic test_walls();
    wall_e = 1'b1;
    set_key(8'h07);
    do_tick();
    do_tick();
    n_total += 2;
    if (busy !== 1'b0)
      $display("FAIL wall_e busy got %b want 0",
               busy);
    else n_pass++;
    if (tile_x !== 5'd2)
      $display("FAIL wall_e tx got %0d want 2",
               tile_x);
    else n_pass++;
    wall_e = 1'b0;
    set_key(8'h00);
    for (int m = 0; m < 2; m++) begin
      set_key(8'h04);
      repeat (6) do_tick();
      set_key(8'h00);
    end
    n_total++;
    if (tile_x !== 5'd0)
      $display("FAIL left2 tx got %0d want 0",
               tile_x);
    else n_pass++;
    set_key(8'h04);
    do_tick();
    do_tick();
    n_total += 2;
    if (busy !== 1'b0)
      $display("FAIL edge busy got %b want 0",
               busy);
    else n_pass++;
    if (tile_x !== 5'd0)
      $display("FAIL edge tx got %0d want 0",
               tile_x);
    else n_pass++;
    set_key(8'h00);
  endtask

  task automatic test_hold();
    int want;
    apply_reset();
    set_key(8'h07);
    repeat (12) do_tick();
    want = REPEAT ? 3 : 2;
    n_total += 2;
    if (tile_x !== 5'(want))
      $display("FAIL hold12 tx got %0d want %0d",
               tile_x, want);
    else n_pass++;
    if (busy !== 1'(m_moving))
      $display("FAIL hold12 busy got %b want %b",
               busy, m_moving);
    else n_pass++;
    set_key(8'h00);
    set_key(8'h07);
    repeat (6) do_tick();
    n_total++;
    if (tile_x !== 5'(m_tx))
      $display("FAIL rehold tx got %0d want %0d",
               tile_x, m_tx);
    else n_pass++;
    set_key(8'h00);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    set_key(8'h07);
    repeat (3) do_tick();
    @(negedge vga_clk);
    #1 reset_n = 1'b0;
    model_reset();
    #1;
    n_total += 2;
    if (tile_x !== 5'd1 || tile_y !== 5'd1)
      $display("FAIL rmid tile got %0d,%0d want 1,1",
               tile_x, tile_y);
    else n_pass++;
    if (busy !== 1'b0)
      $display("FAIL rmid busy got %b want 0",
               busy);
    else n_pass++;
    keycode = 8'h00;
    @(negedge vga_clk) reset_n = 1'b1;
    drive_pix(23, 20, 1);
    n_total++;
    if (DistX !== 20'd3 || DistY !== 20'd0
        || sprite_blank !== 1'b1)
      $display("FAIL rmid_pix got %0d %0d %b want 3 0 1",
               DistX, DistY, sprite_blank);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] keys [6];
    int x, y, ex, ey, px, py;
    bit es;
    keys = '{8'h1A, 8'h16, 8'h04,
             8'h07, 8'h00, 8'h55};
    for (int i = 0; i < 40; i++) begin
      set_key(keys[$urandom_range(0, 5)]);
      wall_n = ($urandom_range(0, 3) == 0);
      wall_e = ($urandom_range(0, 3) == 0);
      wall_s = ($urandom_range(0, 3) == 0);
      wall_w = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(1, 3)) do_tick();
      n_total += 2;
      if (tile_x !== 5'(m_tx)
          || tile_y !== 5'(m_ty))
        $display("FAIL rnd%0d tile got %0d,%0d want %0d,%0d",
                 i, tile_x, tile_y, m_tx, m_ty);
      else n_pass++;
      if (busy !== 1'(m_moving))
        $display("FAIL rnd%0d busy got %b want %b",
                 i, busy, m_moving);
      else n_pass++;
      px = m_tx * 20 + $urandom_range(0, 29) - 5;
      py = m_ty * 20 + $urandom_range(0, 29) - 5;
      x = (px < 0) ? 0 : px;
      y = (py < 0) ? 0 : py;
      drive_pix(x, y, 1);
      exp_pix(x, y, 1, ex, ey, es);
      n_total++;
      if (DistX !== 20'(ex) || DistY !== 20'(ey)
          || sprite_blank !== es)
        $display("FAIL rnd%0d pix got %0d %0d %b want %0d %0d %b",
                 i, DistX, DistY,
                 sprite_blank, ex, ey, es);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_pixel();
    test_move_right();
    test_walls();
    test_hold();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed",
             n_pass, n_total);
    $finish;
  end

endmodule
